ecc_scalar_mult: RTL and testbench

ECC_SCALAR_MULT -- requirements
Module: ecc_scalar_mult

---
 rtl/ecc_pkg.sv | 39 +++
 rtl/ecc_op_watchdog.sv | 30 +++
 rtl/ecc_scalar_mult.sv | 172 +++++++++++++++++
 tb/tb_ecc_scalar_mult.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared types and constants for the scalar multiplier and its point-unit handshake.
package ecc_pkg;

    localparam int PW      = 80;
    localparam int DBL_BIT = 79;
    localparam int NEG_BIT = 79;

    typedef enum logic [2:0] {
        IDLE,
        BIT,
        DBL_REQ,
        DBL_WAIT,
        ADD_REQ,
        ADD_WAIT,
        NEXT,
        FIN
    } state_t;

    typedef struct packed {
        logic [PW-1:0] x;
        logic [PW-1:0] y;
    } point_t;

    localparam point_t POINT_O = '{default: '0};

    // Bit 79 of every coordinate is a flag position on the unit bus, never coordinate data.
    function automatic point_t mask_point(input point_t p);
        point_t m;
        m = p;
        m.x[PW-1] = 1'b0;
        m.y[PW-1] = 1'b0;
        return m;
    endfunction

    function automatic logic is_o(input point_t p);
        return (p == POINT_O);
    endfunction

endpackage

// File: rtl/ecc_op_watchdog.sv
// Per-operation cycle watchdog: cleared by load, advances while count is high,
// and holds expire once TIMEOUT cycles have elapsed.
module ecc_op_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (count && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/ecc_scalar_mult.sv
// Left-to-right double-and-add scalar multiplier driving an external point unit;
// the accumulator skips doublings of O and turns O + G into a direct copy of G.
module ecc_scalar_mult
    import ecc_pkg::*;
#(
    parameter int KW      = 80,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [KW-1:0] k,
    input  logic [PW-1:0] gx,
    input  logic [PW-1:0] gy,
    output logic [PW-1:0] rx,
    output logic [PW-1:0] ry,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [PW-1:0] ecc_px,
    output logic [PW-1:0] ecc_py,
    output logic [PW-1:0] ecc_qx,
    output logic [PW-1:0] ecc_qy,
    output logic          ecc_start,
    input  logic          ecc_done,
    input  logic [PW-1:0] ecc_rx,
    input  logic [PW-1:0] ecc_ry
);

    localparam int IW = $clog2(KW);

    state_t        state, next_state;
    logic [KW-1:0] k_q;
    point_t        g_q, r_q, r_next, unit_res;
    logic [IW-1:0] bit_idx;
    logic          ecc_done_q, ecc_edge, cur_bit;
    logic          wd_load, wd_count, wd_expire, timed_out;

    assign ecc_edge = ecc_done && !ecc_done_q;
    assign cur_bit  = k_q[bit_idx];
    assign unit_res = mask_point({ecc_rx, ecc_ry});

    ecc_op_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .load   (wd_load),
        .count  (wd_count),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        r_next     = r_q;
        wd_load    = 1'b0;
        wd_count   = 1'b0;
        unique case (state)
            IDLE: if (start) next_state = BIT;
            BIT: begin
                if (!is_o(r_q)) begin
                    next_state = DBL_REQ;
                end else begin
                    if (cur_bit) r_next = g_q;
                    next_state = NEXT;
                end
            end
            DBL_REQ: begin
                wd_load    = 1'b1;
                next_state = DBL_WAIT;
            end
            DBL_WAIT: begin
                wd_count = 1'b1;
                if (wd_expire) begin
                    next_state = FIN;
                end else if (ecc_edge) begin
                    // A doubling that lands on O makes the pending add a plain copy of G.
                    if (cur_bit && !is_o(unit_res)) begin
                        r_next     = unit_res;
                        next_state = ADD_REQ;
                    end else begin
                        r_next     = cur_bit ? g_q : unit_res;
                        next_state = NEXT;
                    end
                end
            end
            ADD_REQ: begin
                wd_load    = 1'b1;
                next_state = ADD_WAIT;
            end
            ADD_WAIT: begin
                wd_count = 1'b1;
                if (wd_expire) begin
                    next_state = FIN;
                end else if (ecc_edge) begin
                    r_next     = unit_res;
                    next_state = NEXT;
                end
            end
            NEXT:    next_state = (bit_idx == '0) ? FIN : BIT;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q        <= '0;
            g_q        <= POINT_O;
            r_q        <= POINT_O;
            bit_idx    <= '0;
            ecc_done_q <= 1'b0;
            timed_out  <= 1'b0;
            rx         <= '0;
            ry         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ecc_start  <= 1'b0;
            ecc_px     <= '0;
            ecc_py     <= '0;
            ecc_qx     <= '0;
            ecc_qy     <= '0;
        end else begin
            ecc_done_q <= ecc_done;
            r_q        <= r_next;
            ecc_start  <= (next_state == DBL_REQ) || (next_state == ADD_REQ);
            done       <= (state == FIN);
            err        <= (state == FIN) && timed_out;

            if (state == IDLE && start) begin
                k_q       <= k;
                g_q       <= mask_point({gx, gy});
                r_q       <= POINT_O;
                bit_idx   <= IW'(KW - 1);
                busy      <= 1'b1;
                timed_out <= 1'b0;
            end

            if (state == NEXT && bit_idx != '0) bit_idx <= bit_idx - 1'b1;

            if ((state == DBL_WAIT || state == ADD_WAIT) && wd_expire) timed_out <= 1'b1;

            // Operands load on entry to a request state and stay put through the wait.
            if (next_state == DBL_REQ) begin
                ecc_px <= {1'b1, r_next.x[PW-2:0]};
                ecc_py <= {1'b0, r_next.y[PW-2:0]};
                ecc_qx <= '0;
                ecc_qy <= '0;
            end else if (next_state == ADD_REQ) begin
                ecc_px <= r_next.x;
                ecc_py <= r_next.y;
                ecc_qx <= g_q.x;
                ecc_qy <= g_q.y;
            end

            if (state == FIN) begin
                busy <= 1'b0;
                rx   <= timed_out ? '0 : r_q.x;
                ry   <= timed_out ? '0 : r_q.y;
            end
        end
    end

endmodule

// File: tb/tb_ecc_scalar_mult.sv
// Directed bench for ecc_scalar_mult with a behavioural point unit that answers 20 cycles
// after each ecc_start using simple stand-in arithmetic for doubling and addition.
module tb_ecc_scalar_mult;

    localparam int KW      = 80;
    localparam int TIMEOUT = 4096;
    localparam logic [79:0] GX = 80'h30CB127B63E42792F10F;
    localparam logic [79:0] GY = 80'h547B2C88266BB04F713B;

    typedef struct packed {
        logic [79:0] x;
        logic [79:0] y;
    } pt_t;

    typedef struct {
        logic [79:0] kk;
        pt_t         exp;
        int          calls;
        int          cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [79:0] k_in, gx_in, gy_in;
    logic [79:0] rx, ry, ecc_px, ecc_py, ecc_qx, ecc_qy;
    logic        busy, done, err, ecc_start;
    logic        ecc_done = 1'b0;
    logic [79:0] ecc_rx = '0, ecc_ry = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    bit pu_hang = 1'b0;
    int pu_wait = 0;
    int pu_hold = 0;
    pt_t pu_res;
    logic [79:0] log_px[$], log_py[$], log_qx[$], log_qy[$];

    ecc_scalar_mult #(.KW(KW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k         (k_in),
        .gx        (gx_in),
        .gy        (gy_in),
        .rx        (rx),
        .ry        (ry),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ecc_px    (ecc_px),
        .ecc_py    (ecc_py),
        .ecc_qx    (ecc_qx),
        .ecc_qy    (ecc_qy),
        .ecc_start (ecc_start),
        .ecc_done  (ecc_done),
        .ecc_rx    (ecc_rx),
        .ecc_ry    (ecc_ry)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic pt_t mk(input logic [79:0] x, input logic [79:0] y);
        pt_t p;
        p.x = x;
        p.y = y;
        p.x[79] = 1'b0;
        p.y[79] = 1'b0;
        return p;
    endfunction

    // Stand-in point arithmetic; results may carry bit 79, which the DUT must drop.
    function automatic pt_t pu_dbl(input pt_t a);
        pt_t r;
        r.x = a.x + a.y + 80'd1;
        r.y = a.x ^ (a.y << 1);
        return r;
    endfunction

    function automatic pt_t pu_add(input pt_t a, input pt_t b);
        pt_t r;
        r.x = a.x + b.x + 80'd2;
        r.y = a.y ^ b.y ^ 80'd5;
        return r;
    endfunction

    function automatic void ref_mult(input logic [79:0] kk, output pt_t res, output int calls);
        pt_t g, r;
        g = mk(GX, GY);
        r = '0;
        calls = 0;
        for (int i = 79; i >= 0; i--) begin
            if (r != '0) begin
                r = pu_dbl(r);
                r = mk(r.x, r.y);
                calls++;
            end
            if (kk[i]) begin
                if (r == '0) begin
                    r = g;
                end else begin
                    r = pu_add(r, g);
                    r = mk(r.x, r.y);
                    calls++;
                end
            end
        end
        res = r;
    endfunction

    // Point unit: latches operands while ecc_start is high, answers 20 cycles later.
    always @(negedge clk) begin
        if (pu_hold > 0) begin
            pu_hold--;
            if (pu_hold == 0) ecc_done = 1'b0;
        end
        if (pu_wait > 0) begin
            pu_wait--;
            if (pu_wait == 0) begin
                ecc_rx   = pu_res.x;
                ecc_ry   = pu_res.y;
                ecc_done = 1'b1;
                pu_hold  = 2;
            end
        end
        if (ecc_start === 1'b1) begin
            log_px.push_back(ecc_px);
            log_py.push_back(ecc_py);
            log_qx.push_back(ecc_qx);
            log_qy.push_back(ecc_qy);
            start_cyc = cyc;
            pu_res = ecc_px[79] ? pu_dbl(mk(ecc_px, ecc_py))
                                : pu_add(mk(ecc_px, ecc_py), mk(ecc_qx, ecc_qy));
            if (!pu_hang) pu_wait = 20;
        end
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one multiplication; optionally pokes a competing start/k/G while busy.
    task automatic run_op(input logic [79:0] kk, input int poke_at,
                          output int cycles, output int n_calls, output logic got_err);
        int base;
        base = log_px.size();
        @(negedge clk);
        k_in  = kk;
        gx_in = GX | (80'd1 << 79);
        gy_in = GY | (80'd1 << 79);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", 80'(busy), 80'd1);
        cycles = 0;
        while (done !== 1'b1 && cycles < 20000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cycles == poke_at) begin
                start = 1'b1;
                k_in  = 80'd1;
                gx_in = 80'h1234;
                gy_in = 80'h5678;
            end
            if (cycles == poke_at + 3) start = 1'b0;
        end
        check("done_seen", 80'(done), 80'd1);
        check("busy_low_with_done", 80'(busy), 80'd0);
        got_err  = err;
        done_cyc = cyc;
        n_calls  = log_px.size() - base;
    endtask

    initial begin
        vec_t        vecs[7];
        logic [79:0] ks[7];
        pt_t         g, g2, g3, r_exp;
        int          cycles, n_calls, base, n, seen;
        logic        got_err;
        logic [79:0] rx_hold;

        g  = mk(GX, GY);
        g2 = pu_dbl(g);
        g2 = mk(g2.x, g2.y);
        g3 = pu_add(g2, g);
        g3 = mk(g3.x, g3.y);

        ks[0] = 80'd0;
        ks[1] = 80'd1;
        ks[2] = 80'd2;
        ks[3] = 80'd3;
        ks[4] = 80'd4;
        ks[5] = 80'hA5;
        ks[6] = 80'd1 << 79;
        for (int i = 0; i < 7; i++) begin
            vecs[i].kk = ks[i];
            ref_mult(ks[i], r_exp, n);
            vecs[i].exp   = r_exp;
            vecs[i].calls = n;
            vecs[i].cyc   = (n == 0) ? 2 * KW + 1 : -1;
        end

        reset = 1'b1;
        start = 1'b0;
        k_in  = '0;
        gx_in = '0;
        gy_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx", rx, 80'd0);
        check("rst_ry", ry, 80'd0);
        check("rst_busy", 80'(busy), 80'd0);
        check("rst_done", 80'(done), 80'd0);
        check("rst_err", 80'(err), 80'd0);
        check("rst_ecc_start", 80'(ecc_start), 80'd0);
        check("rst_ecc_px", ecc_px, 80'd0);
        check("rst_ecc_qy", ecc_qy, 80'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].kk, -1, cycles, n_calls, got_err);
            check($sformatf("rx_k%0h", vecs[i].kk), rx, vecs[i].exp.x);
            check($sformatf("ry_k%0h", vecs[i].kk), ry, vecs[i].exp.y);
            check($sformatf("calls_k%0h", vecs[i].kk), 80'(n_calls), 80'(vecs[i].calls));
            check($sformatf("err_k%0h", vecs[i].kk), 80'(got_err), 80'd0);
            if (vecs[i].cyc >= 0)
                check($sformatf("latency_k%0h", vecs[i].kk), 80'(cycles), 80'(vecs[i].cyc));
            rx_hold = rx;
            repeat (3) @(negedge clk);
            check("done_one_cycle", 80'(done), 80'd0);
            check("rx_held", rx, rx_hold);
        end

        // Doubling request operands for k = 2.
        base = log_px.size();
        run_op(80'd2, -1, cycles, n_calls, got_err);
        check("k2_calls", 80'(n_calls), 80'd1);
        check("k2_px", log_px[base], {1'b1, GX[78:0]});
        check("k2_py", log_py[base], {1'b0, GY[78:0]});
        check("k2_qx", log_qx[base], 80'd0);
        check("k2_qy", log_qy[base], 80'd0);
        check("k2_rx", rx, g2.x);

        // k = 3: a doubling, then an add of (2G, G).
        base = log_px.size();
        run_op(80'd3, -1, cycles, n_calls, got_err);
        check("k3_calls", 80'(n_calls), 80'd2);
        check("k3_first_dbl", 80'(log_px[base][79]), 80'd1);
        check("k3_add_flag", 80'(log_px[base+1][79]), 80'd0);
        check("k3_add_px", log_px[base+1], g2.x);
        check("k3_add_py", log_py[base+1], g2.y);
        check("k3_add_qx", log_qx[base+1], GX);
        check("k3_add_qy", log_qy[base+1], GY);
        check("k3_rx", rx, g3.x);
        check("k3_ry", ry, g3.y);

        // Competing start with a new k and G while busy is ignored.
        run_op(80'd3, 30, cycles, n_calls, got_err);
        check("poke_rx", rx, g3.x);
        check("poke_ry", ry, g3.y);
        repeat (10) @(negedge clk);
        check("poke_no_restart", 80'(busy), 80'd0);

        // Point unit never answers: watchdog ends the operation with err.
        pu_hang = 1'b1;
        run_op(80'd2, -1, cycles, n_calls, got_err);
        check("to_err", 80'(got_err), 80'd1);
        check("to_rx", rx, 80'd0);
        check("to_ry", ry, 80'd0);
        check("to_window", 80'((done_cyc - start_cyc >= TIMEOUT) && (done_cyc - start_cyc <= TIMEOUT + 4)), 80'd1);
        pu_hang = 1'b0;

        // Refill rx, then reset in the middle of a doubling wait.
        run_op(80'd3, -1, cycles, n_calls, got_err);
        base = log_px.size();
        @(negedge clk);
        k_in  = 80'd2;
        gx_in = GX;
        gy_in = GY;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (log_px.size() == base && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached_dbl", 80'(log_px.size() - base), 80'd1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_rx", rx, 80'd0);
        check("rst_mid_ry", ry, 80'd0);
        check("rst_mid_busy", 80'(busy), 80'd0);
        check("rst_mid_px", ecc_px, 80'd0);
        check("rst_mid_qx", ecc_qx, 80'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("rst_mid_quiet", 80'(seen), 80'd0);

        run_op(80'd1, -1, cycles, n_calls, got_err);
        check("after_rst_rx", rx, GX);
        check("after_rst_ry", ry, GY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
